// File: rtl/microwave_defs.sv
// rtl/microwave_defs.sv - shared state encodings and BCD constants for the oven controller
package microwave_defs;

   localparam int STATE_W = 3;

   localparam logic [3:0] DIGIT_MAX    = 4'd9;
   localparam logic [3:0] SEC_TENS_MAX = 4'd5;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 3'd0,
      ST_ENTRY   = 3'd1,
      ST_COOKING = 3'd2,
      ST_PAUSED  = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

endpackage

// File: rtl/bcd_down_counter.sv
// rtl/bcd_down_counter.sv - four-digit MM:SS BCD register with shift-in, clamp and countdown
import microwave_defs::*;

module bcd_down_counter (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] din,
   input  logic       shift,
   input  logic       clamp,
   input  logic       dec,
   input  logic       clr,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       zero
);

   assign zero = (sec_ones == 4'd0) && (sec_tens == 4'd0) &&
                 (min_ones == 4'd0) && (min_tens == 4'd0);

   // Digit registers: clear wins, then key shift, then start-time clamp, then one-second borrow chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sec_ones <= 4'd0;
         sec_tens <= 4'd0;
         min_ones <= 4'd0;
         min_tens <= 4'd0;
      end else if (clr) begin
         sec_ones <= 4'd0;
         sec_tens <= 4'd0;
         min_ones <= 4'd0;
         min_tens <= 4'd0;
      end else if (shift) begin
         min_tens <= min_ones;
         min_ones <= sec_tens;
         sec_tens <= sec_ones;
         sec_ones <= din;
      end else if (clamp) begin
         // Keyed seconds such as 99 become 59 so the countdown stays a legal clock value.
         if (sec_tens > SEC_TENS_MAX) begin
            sec_tens <= SEC_TENS_MAX;
            sec_ones <= DIGIT_MAX;
         end
      end else if (dec && !zero) begin
         if (sec_ones != 4'd0) begin
            sec_ones <= sec_ones - 4'd1;
         end else begin
            sec_ones <= DIGIT_MAX;
            if (sec_tens != 4'd0) begin
               sec_tens <= sec_tens - 4'd1;
            end else begin
               sec_tens <= SEC_TENS_MAX;
               if (min_ones != 4'd0) begin
                  min_ones <= min_ones - 4'd1;
               end else begin
                  min_ones <= DIGIT_MAX;
                  min_tens <= min_tens - 4'd1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/cook_controller.sv
// rtl/cook_controller.sv - oven sequencer FSM, key/tick edge detect, magnetron gate (option DONE_BEEP_EN)
import microwave_defs::*;

module cook_controller #(
   parameter int BEEP_SECS = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         d,
   input  logic               loadn,
   input  logic               pgt_1hz,
   input  logic               start,
   input  logic               stop,
   input  logic               clear,
   input  logic               door_closed,
   output logic               encoder_en,
   output logic [3:0]         sec_ones,
   output logic [3:0]         sec_tens,
   output logic [3:0]         min_ones,
   output logic [3:0]         min_tens,
   output logic               mag_on,
   output logic               done,
   output logic [STATE_W-1:0] state
);

   state_t state_q, state_next;
   logic   loadn_q, tick_q;
   logic   key, key_ok, tick, at_one, zero;
   logic   shift, clamp, dec, clr;

   // Edge detectors for the keypad strobe (falling) and the 1 Hz wave (rising).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         loadn_q <= 1'b1;
         tick_q  <= 1'b0;
      end else begin
         loadn_q <= loadn;
         tick_q  <= pgt_1hz;
      end
   end

   assign key    = loadn_q & ~loadn;
   assign key_ok = key && (d <= DIGIT_MAX);
   assign tick   = pgt_1hz & ~tick_q;
   assign at_one = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                   (sec_tens == 4'd0) && (sec_ones == 4'd1);

   bcd_down_counter u_counter (
      .clk      (clk),
      .rst      (rst),
      .din      (d),
      .shift    (shift),
      .clamp    (clamp),
      .dec      (dec),
      .clr      (clr),
      .sec_ones (sec_ones),
      .sec_tens (sec_tens),
      .min_ones (min_ones),
      .min_tens (min_tens),
      .zero     (zero)
   );

`ifdef DONE_BEEP_EN
   localparam int BEEP_W = $clog2(BEEP_SECS + 1);
   logic [BEEP_W-1:0] beep_cnt;
   logic              beep_last;

   assign beep_last = tick && (beep_cnt == BEEP_W'(BEEP_SECS - 1));

   // Counts 1 Hz ticks spent in DONE; restarts whenever the FSM is elsewhere.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beep_cnt <= '0;
      end else if (state_q != ST_DONE) begin
         beep_cnt <= '0;
      end else if (tick) begin
         beep_cnt <= beep_cnt + BEEP_W'(1);
      end
   end
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_next;
      end
   end

   // Next state and counter commands; priority is clear, stop, door open, start.
   always_comb begin
      state_next = state_q;
      shift      = 1'b0;
      clamp      = 1'b0;
      dec        = 1'b0;
      clr        = 1'b0;
      if (clear) begin
         clr        = 1'b1;
         state_next = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_ENTRY: begin
               if (stop) begin
                  clr        = 1'b1;
                  state_next = ST_IDLE;
               end else if (start && door_closed && !zero) begin
                  clamp      = 1'b1;
                  state_next = ST_COOKING;
               end else if (key_ok) begin
                  shift      = 1'b1;
                  state_next = ST_ENTRY;
               end
            end
            ST_COOKING: begin
               // A tick that lands on 00:00 finishes the cook even if stop/door ask to pause.
               dec = tick;
               if (tick && at_one) begin
                  state_next = ST_DONE;
               end else if (stop || !door_closed) begin
                  state_next = ST_PAUSED;
               end
            end
            ST_PAUSED: begin
               if (stop) begin
                  clr        = 1'b1;
                  state_next = ST_IDLE;
               end else if (start && door_closed) begin
                  state_next = ST_COOKING;
               end
            end
            ST_DONE: begin
               if (stop) begin
                  clr        = 1'b1;
                  state_next = ST_IDLE;
               end else begin
`ifdef DONE_BEEP_EN
                  if (beep_last) begin
                     state_next = ST_IDLE;
                  end
`else
                  state_next = ST_IDLE;
`endif
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   assign state      = state_q;
   assign encoder_en = (state_q == ST_IDLE) || (state_q == ST_ENTRY);
   assign mag_on     = (state_q == ST_COOKING) && door_closed;
   assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_cook_controller.sv
// tb/tb_cook_controller.sv - randomized and directed self-checking bench for cook_controller
module tb_cook_controller;

   localparam int BEEP = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] d;
   logic       loadn, pgt_1hz, start, stop, clear, door_closed;
   logic       encoder_en, mag_on, done;
   logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
   logic [2:0] state;

   int errors = 0;
   int checks = 0;

   // Reference: time held as whole minutes and seconds; states by their numeric codes.
   int m_state, m_min, m_sec, m_beep;
   bit m_lq, m_tq;

   cook_controller #(.BEEP_SECS(BEEP)) dut (
      .clk(clk), .rst(rst), .d(d), .loadn(loadn), .pgt_1hz(pgt_1hz),
      .start(start), .stop(stop), .clear(clear), .door_closed(door_closed),
      .encoder_en(encoder_en), .sec_ones(sec_ones), .sec_tens(sec_tens),
      .min_ones(min_ones), .min_tens(min_tens), .mag_on(mag_on), .done(done),
      .state(state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_time();
      return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
   endfunction

   function automatic logic [15:0] dut_time();
      return {min_tens, min_ones, sec_tens, sec_ones};
   endfunction

   task automatic model_reset();
      m_state = 0; m_min = 0; m_sec = 0; m_beep = 0;
      m_lq = 1'b1; m_tq = 1'b0;
   endtask

   task automatic go_idle();
      m_state = 0; m_min = 0; m_sec = 0;
   endtask

   task automatic model_step();
      bit key, tk, zero;
      int v;
      key  = m_lq && !loadn;
      tk   = pgt_1hz && !m_tq;
      m_lq = loadn;
      m_tq = pgt_1hz;
      zero = (m_min == 0) && (m_sec == 0);
      if (m_state != 4) m_beep = 0;
      if (clear) go_idle();
      else begin
         case (m_state)
            0, 1: begin
               if (stop) go_idle();
               else if (start && door_closed && !zero) begin
                  if (m_sec > 59) m_sec = 59;
                  m_state = 2;
               end else if (key && d <= 9) begin
                  v = ((m_min * 100 + m_sec) * 10 + int'(d)) % 10000;
                  m_min = v / 100;
                  m_sec = v % 100;
                  m_state = 1;
               end
            end
            2: begin
               if (tk) begin
                  if (m_sec > 0) m_sec--;
                  else if (m_min > 0) begin m_min--; m_sec = 59; end
               end
               if (tk && m_min == 0 && m_sec == 0) m_state = 4;
               else if (stop || !door_closed) m_state = 3;
            end
            3: begin
               if (stop) go_idle();
               else if (start && door_closed) m_state = 2;
            end
            4: begin
               if (stop) go_idle();
               else begin
`ifdef DONE_BEEP_EN
                  if (tk) begin
                     m_beep++;
                     if (m_beep == BEEP) m_state = 0;
                  end
`else
                  m_state = 0;
`endif
               end
            end
            default: m_state = 0;
         endcase
      end
   endtask

   task automatic compare_all();
      check("state", 32'(state), 32'(m_state));
      check("time", 32'(dut_time()), 32'(exp_time()));
      check("mag_on", 32'(mag_on), 32'((m_state == 2) && door_closed));
      check("done", 32'(done), 32'(m_state == 4));
      check("encoder_en", 32'(encoder_en), 32'(m_state == 0 || m_state == 1));
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
      @(negedge clk);
   endtask

   task automatic key_press(input logic [3:0] val);
      d = val; loadn = 1'b0; cyc();
      loadn = 1'b1; cyc();
   endtask

   task automatic tick_on();
      pgt_1hz = 1'b1; cyc();
   endtask

   task automatic tick_off();
      pgt_1hz = 1'b0; cyc();
   endtask

   initial begin
      rst = 1'b1; d = 4'd0; loadn = 1'b1; pgt_1hz = 1'b0;
      start = 1'b0; stop = 1'b0; clear = 1'b0; door_closed = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_state", 32'(state), 32'd0);
      check("rst_time", 32'(dut_time()), 32'h0000);
      check("rst_encoder_en", 32'(encoder_en), 32'd1);
      check("rst_mag_on", 32'(mag_on), 32'd0);
      check("rst_done", 32'(done), 32'd0);

      // Entry of 01:05
      key_press(4'd1); key_press(4'd0); key_press(4'd5);
      check("entry_time", 32'(dut_time()), 32'h0105);
      check("entry_state", 32'(state), 32'd1);
      check("entry_encoder_en", 32'(encoder_en), 32'd1);

      // Full countdown
      start = 1'b1; cyc(); start = 1'b0;
      check("cook_state", 32'(state), 32'd2);
      for (int i = 1; i <= 65; i++) begin
         tick_on();
         check("cook_mag_on", 32'(mag_on), 32'(i < 65));
         if (i == 5) check("cook_at_5", 32'(dut_time()), 32'h0100);
         if (i == 6) check("cook_at_6", 32'(dut_time()), 32'h0059);
         if (i == 65) begin
            check("cook_end_time", 32'(dut_time()), 32'h0000);
            check("cook_end_state", 32'(state), 32'd4);
            check("cook_end_done", 32'(done), 32'd1);
         end
         tick_off();
      end
`ifdef DONE_BEEP_EN
      check("beep_hold_state", 32'(state), 32'd4);
      tick_on(); tick_off(); tick_on(); tick_off();
      check("beep_hold_done", 32'(done), 32'd1);
      tick_on();
      check("beep_exit_state", 32'(state), 32'd0);
      check("beep_exit_done", 32'(done), 32'd0);
      tick_off();
`else
      check("done_pulse_state", 32'(state), 32'd0);
      check("done_pulse_done", 32'(done), 32'd0);
`endif

      // Clamp 00:99 to 00:59
      key_press(4'd0); key_press(4'd9); key_press(4'd9);
      check("clamp_entry", 32'(dut_time()), 32'h0099);
      start = 1'b1; cyc(); start = 1'b0;
      check("clamp_time", 32'(dut_time()), 32'h0059);
      check("clamp_state", 32'(state), 32'd2);
      clear = 1'b1; cyc(); clear = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      check("zero_start_state", 32'(state), 32'd0);
      check("zero_start_mag", 32'(mag_on), 32'd0);

      // Door sequence at 00:30
      key_press(4'd3); key_press(4'd0);
      start = 1'b1; cyc(); start = 1'b0;
      door_closed = 1'b0;
      #1;
      check("door_mag_comb", 32'(mag_on), 32'd0);
      cyc();
      check("door_paused", 32'(state), 32'd3);
      repeat (3) begin tick_on(); tick_off(); end
      check("door_held_time", 32'(dut_time()), 32'h0030);
      door_closed = 1'b1; start = 1'b1; cyc(); start = 1'b0;
      check("door_resume", 32'(state), 32'd2);
      stop = 1'b1; cyc();
      check("stop_pause", 32'(state), 32'd3);
      cyc(); stop = 1'b0;
      check("stop_idle_state", 32'(state), 32'd0);
      check("stop_idle_time", 32'(dut_time()), 32'h0000);

      // Tick and stop together at 00:01
      key_press(4'd1);
      start = 1'b1; cyc(); start = 1'b0;
      pgt_1hz = 1'b1; stop = 1'b1; cyc();
      check("tick_stop_done", 32'(state), 32'd4);
      pgt_1hz = 1'b0; stop = 1'b0;
      clear = 1'b1; cyc(); clear = 1'b0;

      // Long strobe and illegal digit
      d = 4'd7; loadn = 1'b0; repeat (5) cyc();
      loadn = 1'b1; cyc();
      check("long_strobe", 32'(dut_time()), 32'h0007);
      key_press(4'd12);
      check("bad_digit", 32'(dut_time()), 32'h0007);
      clear = 1'b1; cyc(); clear = 1'b0;

      // Reset mid-cook
      key_press(4'd5);
      start = 1'b1; cyc(); start = 1'b0;
      cyc();
      rst = 1'b1;
      #1;
      check("arst_mag_on", 32'(mag_on), 32'd0);
      check("arst_state", 32'(state), 32'd0);
      check("arst_time", 32'(dut_time()), 32'h0000);
      check("arst_encoder_en", 32'(encoder_en), 32'd1);
      check("arst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         d = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) loadn = ~loadn;
         if ($urandom_range(0, 2) == 0) pgt_1hz = ~pgt_1hz;
         start       = ($urandom_range(0, 9) == 0);
         stop        = ($urandom_range(0, 39) == 0);
         clear       = ($urandom_range(0, 79) == 0);
         door_closed = ($urandom_range(0, 19) != 0);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
